// File: rtl/exe_divider_32b.sv
// exe_divider_32b: multicycle radix-2 restoring DIV/DIVU for the EXE stage; optional DIVIDER_ABORT_EN adds a flush-cancel input
module exe_divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIVIDER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a_r, b_r, dvd, rem;
    logic q_neg, r_neg, zero, kill;
    logic [WIDTH-1:0] a_mag, b_mag, q_next, rem_next, q_fin, r_fin;
    logic [WIDTH:0] rem_sh, trial;
`ifdef DIVIDER_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif
    // operand magnitudes, one restoring step, and sign/zero correction of the final results
    always_comb begin
        a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
        rem_sh   = {rem, dvd[WIDTH-1]};
        trial    = rem_sh - {1'b0, b_r};
        q_next   = {dvd[WIDTH-2:0], ~trial[WIDTH]};
        rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        q_fin    = zero ? '1 : (q_neg ? -dvd : dvd);
        r_fin    = zero ? a_r : (r_neg ? -rem : rem);
    end
    // control FSM and datapath registers; the dividend register fills with quotient bits as it shifts out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            dvd         <= '0;
            rem         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= CALC;
                    busy  <= 1'b1;
                    a_r   <= a;
                    dvd   <= a_mag;
                    b_r   <= b_mag;
                    q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg <= is_signed & a[WIDTH-1];
                    zero  <= (b == '0);
                    rem   <= '0;
                    cnt   <= CW'(WIDTH - 1);
                end
            end else if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (state == CALC) begin
                dvd <= q_next;
                rem <= rem_next;
                cnt <= cnt - CW'(1);
                if (cnt == '0) state <= FIX;
            end else begin
                state       <= IDLE;
                busy        <= 1'b0;
                done        <= 1'b1;
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= zero;
            end
        end
    end
endmodule

// File: tb/tb_exe_divider_32b.sv
// tb_exe_divider_32b: scoreboard bench for exe_divider_32b (DIVIDER_ABORT_EN optional)
module tb_exe_divider_32b;
    localparam int W = 32;
    logic clk = 0, rst_n = 0, start = 0, is_signed = 0;
    logic [W-1:0] a = '0, b = '0;
`ifdef DIVIDER_ABORT_EN
    logic abort = 0;
`endif
    logic busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           t;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0, n_err = 0, cyc = 0;
    logic prev_done = 0;
    logic [W-1:0] last_q = '0, last_r = '0;
    logic last_z = 0;

    exe_divider_32b #(.WIDTH(W)) dut (
`ifdef DIVIDER_ABORT_EN
        .abort(abort),
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        e.t = cyc;
        e.z = (y == 0);
        if (y == 0) begin
            e.q = '1;
            e.r = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 0;
        end else if (s) begin
            e.q = $signed(x) / $signed(y);
            e.r = $signed(x) % $signed(y);
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            chk("done_consecutive", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", {32'd0, quotient}, {32'd0, mon_e.q});
                chk("remainder", {32'd0, remainder}, {32'd0, mon_e.r});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.z});
                chk("latency", 64'(cyc - mon_e.t), 64'(W + 2));
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                last_q = mon_e.q;
                last_r = mon_e.r;
                last_z = mon_e.z;
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s, input bit push);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got busy=1 expected idle (cycle %0d)", cyc);
        end
        start = 1;
        a = ia;
        b = ib;
        is_signed = s;
        if (push) sb.push_back(model(ia, ib, s));
        @(negedge clk);
        start = 0;
        a = $urandom;
        b = $urandom;
        is_signed = $urandom_range(0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_done"}, {63'd0, done}, 64'd0);
        chk({name, "_q"}, {32'd0, quotient}, 64'd0);
        chk({name, "_r"}, {32'd0, remainder}, 64'd0);
        chk({name, "_dz"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [W-1:0] ra, rb;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;
        @(negedge clk);
        issue(100, 7, 0, 1);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(bc), 64'(W + 1));
        #1;
        drain();
        issue(10, 32'hFFFF_FFFE, 1, 1);
        issue(32'hFFFF_FFF9, 2, 1, 1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        issue(10, 0, 0, 1);
        issue(10, 0, 1, 1);
        drain();
        issue(100, 7, 0, 1);
        repeat (10) @(negedge clk);
        start = 1;
        a = 50;
        b = 5;
        @(negedge clk);
        start = 0;
        drain();
        issue(100, 10, 0, 1);
        drain();
        issue(12345, 67, 0, 0);
        repeat (9) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk_zero("midop_reset");
        rst_n = 1;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset_busy", {63'd0, busy}, 64'd0);
`ifdef DIVIDER_ABORT_EN
        issue(1000, 33, 1, 1);
        drain();
        issue(777, 5, 0, 0);
        repeat (9) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_q_held", {32'd0, quotient}, {32'd0, last_q});
        chk("abort_r_held", {32'd0, remainder}, {32'd0, last_r});
        chk("abort_dz_held", {63'd0, div_by_zero}, {63'd0, last_z});
        repeat (40) @(negedge clk);
        abort = 1;
        issue(81, 9, 0, 1);
        abort = 0;
        drain();
`endif
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(0, 15);
                1: rb = 0;
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            issue(ra, rb, $urandom_range(0, 1), 1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
